// File: rtl/alu_pkg.sv
// Shared opcodes, opcode width and FSM state encoding for alu_multiciclo.
// The DIV state exists only when ALU_MULTICICLO_DIV_EN is defined.
package alu_pkg;

    localparam int LARGURA_OP = 4;

    localparam logic [LARGURA_OP-1:0] OP_AND   = 4'b0000;
    localparam logic [LARGURA_OP-1:0] OP_OR    = 4'b0001;
    localparam logic [LARGURA_OP-1:0] OP_ADD   = 4'b0010;
    localparam logic [LARGURA_OP-1:0] OP_SUB   = 4'b0110;
    localparam logic [LARGURA_OP-1:0] OP_SLT   = 4'b0111;
    localparam logic [LARGURA_OP-1:0] OP_NOR   = 4'b1100;
    localparam logic [LARGURA_OP-1:0] OP_MULTU = 4'b1000;
    localparam logic [LARGURA_OP-1:0] OP_DIVU  = 4'b1001;
    localparam logic [LARGURA_OP-1:0] OP_MFHI  = 4'b1010;
    localparam logic [LARGURA_OP-1:0] OP_MFLO  = 4'b1011;

`ifdef ALU_MULTICICLO_DIV_EN
    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FIM    = 2'd3
    } estado_t;
`else
    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        MULT   = 2'd1,
        FIM    = 2'd3
    } estado_t;
`endif

endpackage

// File: rtl/alu_multiciclo_if.sv
// Request/result bundle between the register-read stage and alu_multiciclo.
interface alu_multiciclo_if #(
    parameter int LARGURA = 32
) ();
    logic [LARGURA-1:0]             entrada1;
    logic [LARGURA-1:0]             entrada2;
    logic [alu_pkg::LARGURA_OP-1:0] operacao;
    logic                           valido;
    logic                           pronto;
    logic [LARGURA-1:0]             saida;
    logic                           saidaValida;
    logic                           zero;
    logic                           overflow;
    logic                           divZero;
    logic [LARGURA-1:0]             hi;
    logic [LARGURA-1:0]             lo;

    modport master (
        output entrada1, entrada2, operacao, valido,
        input  pronto, saida, saidaValida, zero, overflow, divZero, hi, lo
    );

    modport slave (
        input  entrada1, entrada2, operacao, valido,
        output pronto, saida, saidaValida, zero, overflow, divZero, hi, lo
    );
endinterface

// File: rtl/mult_div_iterativo.sv
// Iterative unsigned shift-add multiplier and (with ALU_MULTICICLO_DIV_EN) restoring divider.
// One bit per cycle, LARGURA cycles; result held in resHi/resLo until the next inicio.
module mult_div_iterativo #(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inicio,
`ifdef ALU_MULTICICLO_DIV_EN
    input  logic               divisao,
    output logic               modoDiv,
    output logic               divZero,
`endif
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    output logic               ocupado,
    output logic               fim,
    output logic [LARGURA-1:0] resHi,
    output logic [LARGURA-1:0] resLo
);
    localparam int CW = $clog2(LARGURA + 1);

    logic [LARGURA-1:0] regHi, regLo, regB;
    logic [LARGURA-1:0] passoHi, passoLo;
    logic [LARGURA:0]   somaM;
    logic [CW-1:0]      cnt;
    logic               ocupadoReg;
`ifdef ALU_MULTICICLO_DIV_EN
    logic               modoDivReg, divZeroReg;
    logic [LARGURA:0]   desloc, difD;
`endif

    // Multiply: {regHi,regLo} is the product shift register, regLo starts as multiplier.
    // Divide: regHi is the partial remainder, regLo shifts dividend out and quotient in.
    always_comb begin
        somaM   = {1'b0, regHi} + (regLo[0] ? {1'b0, regB} : '0);
        passoHi = somaM[LARGURA:1];
        passoLo = {somaM[0], regLo[LARGURA-1:1]};
`ifdef ALU_MULTICICLO_DIV_EN
        desloc = {regHi, regLo[LARGURA-1]};
        difD   = desloc - {1'b0, regB};
        if (modoDivReg) begin
            passoHi = difD[LARGURA] ? desloc[LARGURA-1:0] : difD[LARGURA-1:0];
            passoLo = {regLo[LARGURA-2:0], ~difD[LARGURA]};
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            regHi      <= '0;
            regLo      <= '0;
            regB       <= '0;
            cnt        <= '0;
            ocupadoReg <= 1'b0;
`ifdef ALU_MULTICICLO_DIV_EN
            modoDivReg <= 1'b0;
            divZeroReg <= 1'b0;
`endif
        end else if (inicio) begin
            regHi      <= '0;
            regLo      <= a;
            regB       <= b;
            cnt        <= CW'(LARGURA);
            ocupadoReg <= 1'b1;
`ifdef ALU_MULTICICLO_DIV_EN
            modoDivReg <= divisao;
            divZeroReg <= 1'b0;
            if (divisao && (b == '0)) begin
                regHi      <= a;
                regLo      <= '1;
                cnt        <= '0;
                ocupadoReg <= 1'b0;
                divZeroReg <= 1'b1;
            end
`endif
        end else if (ocupadoReg) begin
            regHi <= passoHi;
            regLo <= passoLo;
            cnt   <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                ocupadoReg <= 1'b0;
            end
        end
    end

    assign ocupado = ocupadoReg;
    assign fim     = ocupadoReg && (cnt == CW'(1));
    assign resHi   = regHi;
    assign resLo   = regLo;
`ifdef ALU_MULTICICLO_DIV_EN
    assign modoDiv = modoDivReg;
    assign divZero = divZeroReg;
`endif

endmodule

// File: rtl/alu_multiciclo.sv
// MIPS ALU with registered result, valid/ready handshake and iterative MULTU/DIVU into HI/LO.
// Define ALU_MULTICICLO_DIV_EN to build the divider; otherwise DIVU is an invalid opcode.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int LARGURA = 32
) (
    input  logic            clock,
    input  logic            reset,
    alu_multiciclo_if.slave bus
);
    // OCIOSO accepts requests | MULT/DIV iterating | FIM writes HI/LO and result
    estado_t estado, proximo;

    logic [LARGURA-1:0] opA, opB, soma, dif, resUnico, resHi, resLo;
    logic [LARGURA-1:0] saidaReg, hiReg, loReg;
    logic               ovfUnico, saidaValidaReg, zeroReg, overflowReg;
    logic               pronto, aceita, ehMulti, inicio, ocupado, fim;
`ifdef ALU_MULTICICLO_DIV_EN
    logic               modoDiv, divZeroRes, divZeroReg;
`endif

    assign opA    = bus.entrada1;
    assign opB    = bus.entrada2;
    assign soma   = opA + opB;
    assign dif    = opA - opB;
    assign pronto = (estado == OCIOSO);
    assign aceita = bus.valido && pronto;

`ifdef ALU_MULTICICLO_DIV_EN
    assign ehMulti = (bus.operacao == OP_MULTU) || (bus.operacao == OP_DIVU);
`else
    assign ehMulti = (bus.operacao == OP_MULTU);
`endif

    always_comb begin
        resUnico = '0;
        ovfUnico = 1'b0;
        case (bus.operacao)
            OP_AND:  resUnico = opA & opB;
            OP_OR:   resUnico = opA | opB;
            OP_ADD: begin
                resUnico = soma;
                ovfUnico = (opA[LARGURA-1] == opB[LARGURA-1]) && (soma[LARGURA-1] != opA[LARGURA-1]);
            end
            OP_SUB: begin
                resUnico = dif;
                ovfUnico = (opA[LARGURA-1] != opB[LARGURA-1]) && (dif[LARGURA-1] != opA[LARGURA-1]);
            end
            OP_SLT:  resUnico = {{(LARGURA-1){1'b0}}, ($signed(opA) < $signed(opB))};
            OP_NOR:  resUnico = ~(opA | opB);
            OP_MFHI: resUnico = hiReg;
            OP_MFLO: resUnico = loReg;
            default: resUnico = '0;
        endcase
    end

    mult_div_iterativo #(.LARGURA(LARGURA)) uMultDiv (
        .clock   (clock),
        .reset   (reset),
        .inicio  (inicio),
`ifdef ALU_MULTICICLO_DIV_EN
        .divisao (bus.operacao == OP_DIVU),
        .modoDiv (modoDiv),
        .divZero (divZeroRes),
`endif
        .a       (opA),
        .b       (opB),
        .ocupado (ocupado),
        .fim     (fim),
        .resHi   (resHi),
        .resLo   (resLo)
    );

    always_comb begin
        proximo = estado;
        inicio  = 1'b0;
        case (estado)
            OCIOSO: begin
                if (aceita && ehMulti) begin
                    inicio  = 1'b1;
                    proximo = MULT;
`ifdef ALU_MULTICICLO_DIV_EN
                    // A zero divisor is resolved at load time, so skip straight to FIM.
                    if (bus.operacao == OP_DIVU) begin
                        proximo = (opB == '0) ? FIM : DIV;
                    end
`endif
                end
            end
            MULT: begin
                if (fim)           proximo = FIM;
                else if (!ocupado) proximo = OCIOSO;
            end
`ifdef ALU_MULTICICLO_DIV_EN
            DIV: begin
                if (fim)           proximo = FIM;
                else if (!ocupado) proximo = OCIOSO;
            end
`endif
            FIM:     proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado         <= OCIOSO;
            saidaReg       <= '0;
            saidaValidaReg <= 1'b0;
            zeroReg        <= 1'b1;
            overflowReg    <= 1'b0;
            hiReg          <= '0;
            loReg          <= '0;
`ifdef ALU_MULTICICLO_DIV_EN
            divZeroReg     <= 1'b0;
`endif
        end else begin
            estado         <= proximo;
            saidaValidaReg <= 1'b0;
            if (aceita && !ehMulti) begin
                saidaReg       <= resUnico;
                zeroReg        <= (resUnico == '0);
                overflowReg    <= ovfUnico;
                saidaValidaReg <= 1'b1;
            end else if (estado == FIM) begin
                hiReg          <= resHi;
                loReg          <= resLo;
                saidaReg       <= resLo;
                zeroReg        <= (resLo == '0);
                overflowReg    <= 1'b0;
                saidaValidaReg <= 1'b1;
`ifdef ALU_MULTICICLO_DIV_EN
                if (modoDiv) divZeroReg <= divZeroRes;
`endif
            end
        end
    end

    assign bus.pronto      = pronto;
    assign bus.saida       = saidaReg;
    assign bus.saidaValida = saidaValidaReg;
    assign bus.zero        = zeroReg;
    assign bus.overflow    = overflowReg;
    assign bus.hi          = hiReg;
    assign bus.lo          = loReg;
`ifdef ALU_MULTICICLO_DIV_EN
    assign bus.divZero     = divZeroReg;
`else
    assign bus.divZero     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed bench for alu_multiciclo: single-cycle vector table plus multi-cycle sequences.
// DIVU expectations follow whether ALU_MULTICICLO_DIV_EN is defined.
module tb_alu_multiciclo;
    import alu_pkg::*;

    localparam int L = 32;

    typedef struct {
        logic [3:0]   op;
        logic [L-1:0] a;
        logic [L-1:0] b;
        logic [L-1:0] saida;
        logic         zero;
        logic         ovf;
    } vetor_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    alu_multiciclo_if #(.LARGURA(L)) bus ();
    alu_multiciclo #(.LARGURA(L)) dut (.clock(clock), .reset(reset), .bus(bus));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nome, input logic [L-1:0] got, input logic [L-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nome, got, exp);
        end
    endtask

    // Issues one multi-cycle request; lat counts edges from accept to saidaValida (accept edge = 1).
    task automatic runMulti(input logic [3:0] op, input logic [L-1:0] a, input logic [L-1:0] b,
                            output int lat, output int baixos);
        bus.operacao = op;
        bus.entrada1 = a;
        bus.entrada2 = b;
        bus.valido   = 1'b1;
        tick();
        bus.valido = 1'b0;
        lat    = 0;
        baixos = 0;
        for (int k = 0; k < 100; k++) begin
            if (bus.saidaValida) begin
                lat = k + 1;
                break;
            end
            if (!bus.pronto) baixos++;
            tick();
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL timeout op %b: got no saidaValida expected within 100 cycles", op);
        end
    endtask

    vetor_t tab[14];
    int     lat, baixos, pulsos;

    initial begin
        tab[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        tab[1]  = '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
        tab[2]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        tab[3]  = '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
        tab[4]  = '{OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
        tab[5]  = '{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        tab[6]  = '{OP_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0};
        tab[7]  = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
        tab[8]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        tab[9]  = '{4'b0011, 32'h0000000C, 32'h00000022, 32'h00000000, 1'b1, 1'b0};
        tab[10] = '{OP_MFHI, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0};
        tab[11] = '{OP_NOR,  32'h12345678, 32'h0F0F0F0F, 32'hE0C0A080, 1'b0, 1'b0};
        tab[12] = '{OP_SLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0};
        tab[13] = '{OP_ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};

        reset        = 1'b0;
        bus.valido   = 1'b0;
        bus.operacao = OP_AND;
        bus.entrada1 = '0;
        bus.entrada2 = '0;
        tick();
        tick();
        chk("reset pronto", bus.pronto, 1);
        chk("reset saida", bus.saida, 0);
        chk("reset saidaValida", bus.saidaValida, 0);
        chk("reset zero", bus.zero, 1);
        chk("reset overflow", bus.overflow, 0);
        chk("reset divZero", bus.divZero, 0);
        chk("reset hi", bus.hi, 0);
        chk("reset lo", bus.lo, 0);
        reset = 1'b1;
        tick();

        // Back-to-back single-cycle issue: one result per cycle.
        for (int i = 0; i < 14; i++) begin
            bus.operacao = tab[i].op;
            bus.entrada1 = tab[i].a;
            bus.entrada2 = tab[i].b;
            bus.valido   = 1'b1;
            tick();
            chk($sformatf("vet%0d saida", i), bus.saida, tab[i].saida);
            chk($sformatf("vet%0d zero", i), bus.zero, tab[i].zero);
            chk($sformatf("vet%0d overflow", i), bus.overflow, tab[i].ovf);
            chk($sformatf("vet%0d saidaValida", i), bus.saidaValida, 1);
            chk($sformatf("vet%0d pronto", i), bus.pronto, 1);
        end
        bus.valido = 1'b0;
        tick();
        chk("pulse ends saidaValida", bus.saidaValida, 0);
        chk("hold saida", bus.saida, 0);
        chk("hold overflow", bus.overflow, 1);

        runMulti(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, lat, baixos);
        chk("multu latency", lat, 34);
        chk("multu pronto low cycles", baixos, 33);
        chk("multu pronto at result", bus.pronto, 1);
        chk("multu saida", bus.saida, 32'hFFFFFFFE);
        chk("multu lo", bus.lo, 32'hFFFFFFFE);
        chk("multu hi", bus.hi, 32'h00000001);
        chk("multu zero", bus.zero, 0);
        chk("multu clears overflow", bus.overflow, 0);
        tick();
        chk("multu pulse one cycle", bus.saidaValida, 0);

        bus.operacao = OP_MFHI;
        bus.valido   = 1'b1;
        tick();
        chk("mfhi saida", bus.saida, 32'h00000001);
        bus.operacao = OP_MFLO;
        tick();
        chk("mflo saida", bus.saida, 32'hFFFFFFFE);

        // Requests while busy are ignored; operand changes after accept have no effect.
        bus.operacao = OP_MULTU;
        bus.entrada1 = 32'd3;
        bus.entrada2 = 32'd5;
        tick();
        bus.operacao = OP_ADD;
        bus.entrada1 = 32'd1;
        bus.entrada2 = 32'd1;
        pulsos = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 20) bus.valido = 1'b0;
            if (k == 5) begin
                chk("busy hi unchanged", bus.hi, 32'h00000001);
                chk("busy lo unchanged", bus.lo, 32'hFFFFFFFE);
                chk("busy pronto", bus.pronto, 0);
            end
            if (bus.saidaValida) pulsos++;
            tick();
        end
        chk("busy pulse count", pulsos, 1);
        chk("busy multu saida", bus.saida, 32'd15);
        chk("busy multu hi", bus.hi, 32'd0);
        chk("busy multu lo", bus.lo, 32'd15);

`ifdef ALU_MULTICICLO_DIV_EN
        runMulti(OP_DIVU, 32'd100, 32'd7, lat, baixos);
        chk("divu latency", lat, 34);
        chk("divu saida", bus.saida, 32'd14);
        chk("divu lo", bus.lo, 32'd14);
        chk("divu hi", bus.hi, 32'd2);
        chk("divu divZero", bus.divZero, 0);
        runMulti(OP_DIVU, 32'd5, 32'd0, lat, baixos);
        chk("div0 latency", lat, 2);
        chk("div0 pronto low cycles", baixos, 1);
        chk("div0 lo", bus.lo, 32'hFFFFFFFF);
        chk("div0 hi", bus.hi, 32'd5);
        chk("div0 saida", bus.saida, 32'hFFFFFFFF);
        chk("div0 divZero", bus.divZero, 1);
        runMulti(OP_MULTU, 32'd0, 32'd5, lat, baixos);
        chk("multu zero saida", bus.saida, 0);
        chk("multu zero flag", bus.zero, 1);
        chk("divZero sticky across multu", bus.divZero, 1);
        runMulti(OP_DIVU, 32'd9, 32'd3, lat, baixos);
        chk("divu9 lo", bus.lo, 32'd3);
        chk("divu9 hi", bus.hi, 32'd0);
        chk("divu9 divZero cleared", bus.divZero, 0);
`else
        bus.operacao = OP_DIVU;
        bus.entrada1 = 32'd100;
        bus.entrada2 = 32'd7;
        bus.valido   = 1'b1;
        tick();
        bus.valido = 1'b0;
        chk("nodiv saidaValida", bus.saidaValida, 1);
        chk("nodiv saida", bus.saida, 0);
        chk("nodiv zero", bus.zero, 1);
        chk("nodiv pronto", bus.pronto, 1);
        chk("nodiv divZero", bus.divZero, 0);
        chk("nodiv lo untouched", bus.lo, 32'd15);
        runMulti(OP_MULTU, 32'd0, 32'd5, lat, baixos);
        chk("multu zero saida", bus.saida, 0);
        chk("multu zero flag", bus.zero, 1);
`endif

        // Leave nonzero state so the abort is observable.
        runMulti(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, lat, baixos);
        chk("pre-abort hi", bus.hi, 32'h00000001);
        bus.operacao = OP_MULTU;
        bus.entrada1 = 32'd7;
        bus.entrada2 = 32'd9;
        bus.valido   = 1'b1;
        tick();
        bus.valido = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b0;
        tick();
        tick();
        chk("abort pronto", bus.pronto, 1);
        chk("abort hi", bus.hi, 0);
        chk("abort lo", bus.lo, 0);
        chk("abort saida", bus.saida, 0);
        chk("abort zero", bus.zero, 1);
        chk("abort saidaValida", bus.saidaValida, 0);
        reset  = 1'b1;
        pulsos = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.saidaValida) pulsos++;
            tick();
        end
        chk("abort no late result", pulsos, 0);
        chk("abort hi stays", bus.hi, 0);

        runMulti(OP_MULTU, 32'd7, 32'd9, lat, baixos);
        chk("after abort latency", lat, 34);
        chk("after abort lo", bus.lo, 32'd63);
        chk("after abort hi", bus.hi, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
- Parametrised successor to the single-cycle ALU in the MIPS datapath.
- Keeps AND/OR/ADD/SUB/SLT/NOR at configurable width, with registered output and a valid/ready handshake.
- Adds iterative unsigned multiply and divide into internal HI/LO registers, plus MFHI/MFLO reads.
- Sits between the register-file read stage and write-back; the control unit stalls on `pronto`.

Parameters:
- LARGURA, 32, operand/result width in bits (≥ 4).
- LARGURA_OP, 4, opcode width (fixed encoding below).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- entrada1  in  LARGURA  operand A.
- entrada2  in  LARGURA  operand B.
- operacao  in  LARGURA_OP  opcode.
- valido  in  1  request valid.
- pronto  out  1  ready to accept a request.
- saida  out  LARGURA  registered result.
- saidaValida  out  1  one-cycle pulse: saida/zero/overflow are new.
- zero  out  1  saida == 0.
- overflow  out  1  signed overflow of ADD/SUB.
- divZero  out  1  last DIVU had divisor 0 (sticky until next DIVU).
- hi  out  LARGURA  HI register.
- lo  out  LARGURA  LO register.

Behaviour:
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR (bitwise ~(A|B)), 1000 MULTU, 1001 DIVU, 1010 MFHI, 1011 MFLO. Any other code → saida=0, single-cycle.
- Reset (reset=0 at clock edge): FSM→OCIOSO, pronto=1, saida=0, saidaValida=0, zero=1, overflow=0, divZero=0, hi=0, lo=0.
- Reset has priority over everything; it aborts an in-flight MULTU/DIVU and leaves HI/LO=0.
- Accept: a request is taken on an edge where valido & pronto. Inputs are ignored otherwise.
- Single-cycle ops (logic, ADD, SUB, SLT, MFHI, MFLO, invalid):
  - Result is registered at the accept edge; saidaValida=1 for the following cycle.
  - pronto stays 1, so back-to-back issue gives 1 result per cycle.
- Arithmetic: ADD/SUB wrap modulo 2^LARGURA. overflow = signed overflow, written only by ADD/SUB and cleared by every other accepted op.
- SLT: saida = {0…,1} if signed A < B, else 0.
- FSM states: OCIOSO → MULT or DIV → FIM → OCIOSO.
  - MULT: shift-add, one bit per cycle, exactly LARGURA cycles. Then {hi,lo} = A*B unsigned (2·LARGURA bits).
  - DIV: restoring division, exactly LARGURA cycles. Then lo = quotient, hi = remainder.
  - DIV with B==0: goes directly to FIM next cycle; lo = all ones, hi = A, divZero=1. Otherwise divZero=0 at completion.
  - FIM: one cycle; saida = lo, saidaValida=1, pronto returns 1 in the same cycle.
  - pronto=0 from the cycle after accept until FIM. Total latency is LARGURA+2 cycles from accept to saidaValida (2 for div-by-zero).
- HI/LO update only in FIM; MFHI/MFLO issued after FIM read the new values.
- Operands are captured at accept; later changes to entrada1/entrada2 have no effect.
- zero always equals (saida==0), registered with saida.
- saida, zero, overflow and divZero hold their values between saidaValida pulses.

Optional Feature:
- Macro: ALU_MULTICICLO_DIV_EN.
- Defined: DIVU and divZero behave as above.
- Undefined: no divider logic; 1001 is treated as an invalid opcode (saida=0, single-cycle); divZero is tied to 0; the FSM has no DIV state.

Decomposition:
- Package alu_pkg holds:
  - opcode constants (OP_AND … OP_MFLO);
  - FSM state typedef/encoding (OCIOSO, MULT, DIV, FIM);
  - LARGURA_OP.
- One sub-module: mult_div_iterativo.
  - Owns the shift registers, iteration counter, and the HI/LO computation.
  - Handshake: inicio/ocupado/fim.
- The top level holds the single-cycle datapath, handshake, and output registers.

Test Plan:
- Reset held low 2 cycles mid-MULTU (A=7, B=9, cycle 5) → pronto=1, hi=lo=0, saida=0, zero=1, saidaValida=0.
- ADD 0x7FFFFFFF+1 → saida=0x80000000, overflow=1, zero=0. Then SUB 5−5 next cycle → saida=0, zero=1, overflow=0. Results on consecutive cycles.
- SLT A=0xFFFFFFFF (−1), B=1 → saida=1. NOR A=0, B=0 → saida=0xFFFFFFFF.
- MULTU 0xFFFFFFFF×2 → pronto low 33 cycles; saidaValida at cycle 34 with saida=lo=0xFFFFFFFE, hi=1. MFHI next → saida=1.
- DIVU 100÷7 → lo=14, hi=2, divZero=0, latency 34. DIVU 5÷0 → latency 2, lo=0xFFFFFFFF, hi=5, divZero=1.
- Request with valido=1 while pronto=0 → ignored; no extra saidaValida. Build without ALU_MULTICICLO_DIV_EN: DIVU → saida=0 next cycle.
